sysref_align: RTL and testbench

Consumes the PL-domain registered SYSREF (`sysref_adc`) from the PL SYSREF capture stage. Detects SYSREF rising edges and checks that they repeat at a fixed period in `pl_clk` cycles. After a configurable number of consecutive good edges it locks and drives a free-running LMFC-style strobe aligned to SYSREF. Sits directly downstream of the capture flop and feeds the PL framing/sync logic: `locked`, `lmfc_strobe` and `sysref_pulse`.

---
 rtl/sysref_pkg.sv | 16 +
 rtl/sysref_edge_det.sv | 22 ++
 rtl/sysref_align.sv | 114 +++++++++++
 tb/tb_sysref_align.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sysref_pkg.sv
// rtl/sysref_pkg.sv - shared types and defaults for SYSREF alignment
package sysref_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEARCH,
    CHECK,
    LOCKED,
    ERROR
  } sysref_state_t;

  localparam int DEF_SYSREF_PERIOD = 16;
  localparam int DEF_LOCK_COUNT    = 4;
  localparam int EDGE_CNT_W        = 16;

endpackage

// File: rtl/sysref_edge_det.sv
// rtl/sysref_edge_det.sv - rising-edge detector on the captured SYSREF level
module sysref_edge_det (
  input  logic pl_clk,
  input  logic pl_resetn,
  input  logic sysref_adc,
  output logic rise
);

  logic sysref_d;

  // Resetting to 0 makes a level already high at reset release look like an edge.
  always_ff @(posedge pl_clk or negedge pl_resetn) begin
    if (!pl_resetn) begin
      sysref_d <= 1'b0;
    end else begin
      sysref_d <= sysref_adc;
    end
  end

  assign rise = sysref_adc & ~sysref_d;

endmodule

// File: rtl/sysref_align.sv
// rtl/sysref_align.sv - SYSREF period checker, lock FSM and LMFC strobe
module sysref_align
  import sysref_pkg::*;
#(
  parameter int SYSREF_PERIOD = DEF_SYSREF_PERIOD,
  parameter int LOCK_COUNT    = DEF_LOCK_COUNT
) (
  input  logic                  pl_clk,
  input  logic                  pl_resetn,
  input  logic                  sysref_adc,
  input  logic                  arm,
  output logic                  sysref_pulse,
  output logic                  lmfc_strobe,
  output logic                  locked,
  output logic                  period_err,
  output logic [EDGE_CNT_W-1:0] edge_count
);

  localparam int PH_W = $clog2(SYSREF_PERIOD);
  localparam int GC_W = $clog2(LOCK_COUNT + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SYSREF_PERIOD - 1);
  localparam logic [GC_W-1:0] GC_LOCK = GC_W'(LOCK_COUNT);

  sysref_state_t   state;
  logic [PH_W-1:0] phase;
  logic [PH_W-1:0] phase_inc;
  logic [GC_W-1:0] good_cnt;
  logic [GC_W-1:0] good_inc;
  logic            phase_zero;
  logic            rise;

  sysref_edge_det u_edge_det (
    .pl_clk     (pl_clk),
    .pl_resetn  (pl_resetn),
    .sysref_adc (sysref_adc),
    .rise       (rise)
  );

  assign phase_zero = (phase == '0);
  assign phase_inc  = (phase == PH_LAST) ? '0 : phase + PH_W'(1);
  assign good_inc   = good_cnt + GC_W'(1);

  always_ff @(posedge pl_clk or negedge pl_resetn) begin
    if (!pl_resetn) begin
      state        <= IDLE;
      phase        <= '0;
      good_cnt     <= '0;
      sysref_pulse <= 1'b0;
      lmfc_strobe  <= 1'b0;
      locked       <= 1'b0;
      period_err   <= 1'b0;
      edge_count   <= '0;
    end else begin
      sysref_pulse <= 1'b0;
      lmfc_strobe  <= (state == LOCKED) && phase_zero;
      // arm wins over a coincident edge: that edge is neither counted nor used
      if (arm) begin
        state      <= SEARCH;
        good_cnt   <= '0;
        locked     <= 1'b0;
        period_err <= 1'b0;
        edge_count <= '0;
      end else begin
        if (rise && (state != IDLE)) begin
          sysref_pulse <= 1'b1;
          if (edge_count != '1) begin
            edge_count <= edge_count + EDGE_CNT_W'(1);
          end
        end
        case (state)
          IDLE: ;
          SEARCH: begin
            if (rise) begin
              state    <= CHECK;
              phase    <= PH_W'(1);
              good_cnt <= '0;
            end
          end
          CHECK: begin
            if (rise && phase_zero) begin
              good_cnt <= good_inc;
              phase    <= phase_inc;
              if (good_inc == GC_LOCK) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else if (rise) begin
              phase    <= PH_W'(1);
              good_cnt <= '0;
            end else if (phase_zero) begin
              state    <= SEARCH;
              good_cnt <= '0;
              phase    <= phase_inc;
            end else begin
              phase <= phase_inc;
            end
          end
          LOCKED: begin
            // Missing edges are fine here; only an edge off phase 0 is fatal.
            phase <= phase_inc;
            if (rise && !phase_zero) begin
              state      <= ERROR;
              locked     <= 1'b0;
              period_err <= 1'b1;
            end
          end
          ERROR: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sysref_align.sv
// tb/tb_sysref_align.sv - checkpoint table plus edge scoreboard for sysref_align
module tb_sysref_align;

  localparam int P  = 16;
  localparam int LC = 4;
  localparam int E0 = 13;
  localparam int E1 = 353;
  localparam int E2 = 483;
  localparam int LAST_CYC = E2 + 151;

  logic        pl_clk = 1'b0;
  logic        pl_resetn;
  logic        sysref_adc;
  logic        arm;
  logic        sysref_pulse;
  logic        lmfc_strobe;
  logic        locked;
  logic        period_err;
  logic [15:0] edge_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int t;
    int lk;
    int st;
    int er;
    int ec;
  } chk_t;

  typedef struct {
    int due;
    int ec;
  } exp_t;

  chk_t tbl[$];
  exp_t sb[$];
  int   edges[$];
  int   arms[$];
  int   rst_drops[$];
  int   rst_rels[$];
  int   cyc;
  int   exp_ecnt;
  bit   armed;

  sysref_align #(
    .SYSREF_PERIOD (P),
    .LOCK_COUNT    (LC)
  ) dut (
    .pl_clk       (pl_clk),
    .pl_resetn    (pl_resetn),
    .sysref_adc   (sysref_adc),
    .arm          (arm),
    .sysref_pulse (sysref_pulse),
    .lmfc_strobe  (lmfc_strobe),
    .locked       (locked),
    .period_err   (period_err),
    .edge_count   (edge_count)
  );

  always #5 pl_clk = ~pl_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  function automatic bit level(input int c);
    foreach (edges[i]) if (edges[i] <= c && c < edges[i] + 3) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit in_list(input int q[$], input int c);
    foreach (q[i]) if (q[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic add(input int t, input int lk, input int st, input int er, input int ec);
    chk_t c;
    c.t = t; c.lk = lk; c.st = st; c.er = er; c.ec = ec;
    tbl.push_back(c);
  endtask

  task automatic tick();
    bit   a;
    bit   r;
    bit   due;
    exp_t e;
    chk_t c;
    a = in_list(arms, cyc);
    arm = a;
    sysref_adc = level(cyc);
    r = level(cyc) && (cyc == 0 || !level(cyc - 1));
    if (r && !a && armed) begin
      if (exp_ecnt < 16'hFFFF) exp_ecnt++;
      e.due = cyc + 1;
      e.ec  = exp_ecnt;
      sb.push_back(e);
    end
    if (a) begin
      armed    = 1'b1;
      exp_ecnt = 0;
    end
    if (in_list(rst_drops, cyc)) begin
      #1 pl_resetn = 1'b0;
      #1;
      check("rst_async_locked", locked, 0);
      check("rst_async_strobe", lmfc_strobe, 0);
      check("rst_async_pulse", sysref_pulse, 0);
      check("rst_async_err", period_err, 0);
      check("rst_async_edge_count", edge_count, 0);
      sb.delete();
      armed    = 1'b0;
      exp_ecnt = 0;
    end
    if (in_list(rst_rels, cyc)) begin
      #1 pl_resetn = 1'b1;
    end
    @(negedge pl_clk);
    due = 1'b0;
    if (sb.size() > 0) due = (sb[0].due == cyc);
    check("sysref_pulse", sysref_pulse, due);
    if (due) begin
      check("edge_count_sb", edge_count, sb[0].ec);
      void'(sb.pop_front());
    end
    while (tbl.size() > 0 && tbl[0].t == cyc) begin
      c = tbl.pop_front();
      if (c.lk >= 0) check("locked", locked, c.lk);
      if (c.st >= 0) check("lmfc_strobe", lmfc_strobe, c.st);
      if (c.er >= 0) check("period_err", period_err, c.er);
      if (c.ec >= 0) check("edge_count_tbl", edge_count, c.ec);
    end
    @(posedge pl_clk);
    #1;
    cyc++;
  endtask

  initial begin
    // Stimulus schedule: SYSREF rising edges (each held 3 cycles), arms, resets.
    edges.push_back(5);
    for (int k = 0; k <= 6; k++) edges.push_back(E0 + 16 * k);
    edges.push_back(E0 + 272);
    edges.push_back(E0 + 277);
    edges.push_back(E0 + 300);
    foreach (edges[i]) begin end
    edges.push_back(E1);
    edges.push_back(E1 + 16);
    for (int k = 0; k <= 5; k++) edges.push_back(E1 + 33 + 16 * k);
    for (int k = 0; k <= 6; k++) edges.push_back(E2 + 16 * k);
    edges.push_back(E2 + 112);
    edges.push_back(E2 + 128);
    arms.push_back(10);
    arms.push_back(E0 + 330);
    arms.push_back(E2);
    rst_rels.push_back(2);
    rst_drops.push_back(E2 + 97);
    rst_rels.push_back(E2 + 100);

    // Expected output checkpoints, derived from the timing rules.
    for (int t = 0; t <= 12; t++) add(t, 0, 0, 0, 0);
    for (int r = 1; r <= 271; r++)
      add(E0 + r, int'(r >= 65), int'(r >= 81 && (r - 81) % 16 == 0), 0, (r == 65) ? 5 : -1);
    for (int r = 272; r <= 330; r++)
      add(E0 + r, int'(r <= 277), int'(r == 273), int'(r >= 278), -1);
    add(E0 + 331, 0, 0, 0, 0);
    for (int r = 1; r <= 130; r++)
      add(E1 + r, int'(r >= 98), int'(r >= 114 && (r - 114) % 16 == 0), 0, -1);
    for (int r = 1; r <= 96; r++)
      add(E2 + r, int'(r >= 81), 0, 0, (r == 1) ? 0 : ((r == 81) ? 5 : -1));
    for (int r = 97; r <= 150; r++) add(E2 + r, 0, 0, 0, 0);

    pl_resetn  = 1'b0;
    arm        = 1'b0;
    sysref_adc = 1'b0;
    exp_ecnt   = 0;
    armed      = 1'b0;
    cyc        = 0;
    @(posedge pl_clk);
    #1;
    while (cyc < LAST_CYC) tick();

    check("table_drained", tbl.size(), 0);
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
